// File: rtl/video_timing_gen.sv
// Video timing generator: free-running pixel/line counters with registered sync, blank,
// position, start pulses and a look-ahead framebuffer fetch request.
// Define VIDEO_TEST_PATTERN_EN to drive eight vertical colour bars on r/g/b.
module video_timing_gen #(
   parameter int H_ACTIVE   = 1024,
   parameter int H_FP       = 24,
   parameter int H_SYNC     = 136,
   parameter int H_BP       = 144,
   parameter int V_ACTIVE   = 768,
   parameter int V_FP       = 3,
   parameter int V_SYNC     = 6,
   parameter int V_BP       = 29,
   parameter bit HSYNC_POL  = 1'b0,
   parameter bit VSYNC_POL  = 1'b0,
   parameter int FETCH_LEAD = 2
) (
   input  logic        clk_pixel,
   input  logic        rst_n,
   output logic        hsync,
   output logic        vsync,
   output logic        blank,
   output logic [10:0] x,
   output logic [10:0] y,
   output logic        frame_start,
   output logic        line_start,
   output logic        fetch_req,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b
);

   localparam int CW = 12;

   localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] H_TOT    = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] V_TOT    = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP);
   localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] LEAD     = CW'(FETCH_LEAD);

   logic [CW-1:0] h_cnt;
   logic [CW-1:0] v_cnt;
   logic          h_last;
   logic          v_last;

   logic [CW-1:0] fetch_sum;
   logic          fetch_wrap;
   logic [CW-1:0] fetch_tx;
   logic [CW-1:0] fetch_ty;

   logic          blank_nxt;
   logic          hsync_nxt;
   logic          vsync_nxt;
   logic          fetch_nxt;
   logic          frame_start_nxt;
   logic          line_start_nxt;

   assign h_last = (h_cnt == H_TOT - CW'(1));
   assign v_last = (v_cnt == V_TOT - CW'(1));

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= v_last ? '0 : v_cnt + CW'(1);
      end else begin
         h_cnt <= h_cnt + CW'(1);
      end
   end

   // The fetch target wraps into the next line (and the next frame from the last line),
   // so a request is raised only when the pixel it names will actually be displayed.
   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      fetch_sum  = h_cnt + LEAD;
      fetch_wrap = (fetch_sum >= H_TOT);
      fetch_tx   = fetch_wrap ? fetch_sum - H_TOT : fetch_sum;
      fetch_ty   = v_cnt;
      if (fetch_wrap) begin
         fetch_ty = v_last ? '0 : v_cnt + CW'(1);
      end

      blank_nxt       = (h_cnt >= H_ACT) || (v_cnt >= V_ACT);
      hsync_nxt       = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
      vsync_nxt       = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
      fetch_nxt       = (fetch_tx < H_ACT) && (fetch_ty < V_ACT);
      line_start_nxt  = (h_cnt == '0);
      frame_start_nxt = (h_cnt == '0) && (v_cnt == '0);
   end

   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         x           <= '0;
         y           <= '0;
         blank       <= 1'b1;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         fetch_req   <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         x           <= h_cnt[10:0];
         y           <= v_cnt[10:0];
         blank       <= blank_nxt;
         hsync       <= hsync_nxt;
         vsync       <= vsync_nxt;
         fetch_req   <= fetch_nxt;
         line_start  <= line_start_nxt;
         frame_start <= frame_start_nxt;
      end
   end

`ifdef VIDEO_TEST_PATTERN_EN
   localparam logic [14:0] H_ACT_W = 15'(H_ACTIVE);

   logic [14:0] x8;
   logic [2:0]  bar;
   logic [23:0] rgb_nxt;

   // Bar index is only meaningful inside the active line; blanking forces black anyway.
   always_comb begin
      x8      = {h_cnt, 3'b000};
      bar     = 3'(x8 / H_ACT_W);
      rgb_nxt = blank_nxt ? 24'h0 : {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
   end

   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         r <= '0;
         g <= '0;
         b <= '0;
      end else begin
         r <= rgb_nxt[23:16];
         g <= rgb_nxt[15:8];
         b <= rgb_nxt[7:0];
      end
   end
`else
   assign r = '0;
   assign g = '0;
   assign b = '0;
`endif

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1024, visible pixels per line.
REQ-002 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 24 / 136 / 144, horizontal front porch / sync / back porch in pixels; H_TOTAL = sum of all four (1328).
REQ-003 SHALL have parameters V_ACTIVE / V_FP / V_SYNC / V_BP, defaults 768 / 3 / 6 / 29, in lines; V_TOTAL = sum (806).
REQ-004 SHALL have parameters HSYNC_POL / VSYNC_POL, default 0 / 0, asserted sync level (0 = active-low).
REQ-005 SHALL have parameter FETCH_LEAD, default 2, range 1..H_BP, cycles by which fetch_req precedes the pixel it requests.
REQ-006 SHALL have port clk_pixel, input, 1, pixel clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports hsync / vsync / blank, output, 1 each, registered video timing.
REQ-009 SHALL have ports x / y, output, 11 each, position of the current output pixel.
REQ-010 SHALL have port frame_start, output, 1, one-cycle pulse at position (0,0).
REQ-011 SHALL have port line_start, output, 1, one-cycle pulse at x == 0 on every line.
REQ-012 SHALL have port fetch_req, output, 1, framebuffer pixel request FETCH_LEAD cycles ahead.
REQ-013 SHALL have ports r / g / b, output, 8 each, test-pattern colour.

Function
REQ-014 SHALL keep a horizontal counter 0..H_TOTAL-1 that wraps to 0; the vertical counter 0..V_TOTAL-1 increments only on horizontal wrap, and wraps to 0 from V_TOTAL-1.
REQ-015 SHALL register all outputs from the counter state with latency exactly 1 cycle; all outputs stay mutually aligned to the same (x,y).
REQ-016 SHALL assert blank when x >= H_ACTIVE or y >= V_ACTIVE.
REQ-017 SHALL drive hsync = HSYNC_POL for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, otherwise ~HSYNC_POL.
REQ-018 SHALL drive vsync = VSYNC_POL for whole lines V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, changing only at x == 0.
REQ-019 SHALL assert fetch_req when the target position, x+FETCH_LEAD taken modulo H_TOTAL, is active; the target line is y, or (y+1) mod V_TOTAL when x+FETCH_LEAD >= H_TOTAL.
REQ-020 SHALL therefore produce exactly H_ACTIVE fetch_req cycles per active line and H_ACTIVE*V_ACTIVE per frame; none target a blanked line, including across the V_TOTAL-1 -> 0 frame wrap.

Reset
REQ-021 SHALL, while rst_n is low, hold the counters at 0 with x=0, y=0, blank=1, hsync=~HSYNC_POL, vsync=~VSYNC_POL, frame_start=line_start=fetch_req=0 and r=g=b=0.
REQ-022 SHALL, on the first rising edge after rst_n deasserts, present (0,0) with frame_start=1, line_start=1 and blank=0.
REQ-023 SHALL, on assertion of rst_n mid-frame, force the reset values immediately (asynchronously) and restart from (0,0) as in REQ-022.

Configuration
REQ-024 SHALL, with macro VIDEO_TEST_PATTERN_EN defined, drive eight vertical colour bars of width H_ACTIVE/8: bar index i = x*8/H_ACTIVE; r = 8'hFF if i[2] else 0, g = 8'hFF if i[1] else 0, b = 8'hFF if i[0] else 0; r=g=b=0 while blank; colour is registered and aligned with x.
REQ-025 SHALL, without VIDEO_TEST_PATTERN_EN, tie r, g and b to 0 and contain no pattern logic.

Verification
REQ-026 SHALL cover: reset release -> first cycle x=0, y=0, frame_start=1, blank=0; next frame_start exactly 1328*806 = 1070368 cycles later.
REQ-027 SHALL cover: one full line -> hsync low for exactly x = 1048..1183 (136 cycles), blank high for x = 1024..1327.
REQ-028 SHALL cover: one full frame -> vsync low for lines 771..776 only, with edges coincident with x=0; fetch_req count = 786432.
REQ-029 SHALL cover: FETCH_LEAD=2 at x=1326, y=805 -> fetch_req=1 (targets (0,0)); at x=1326, y=767 -> fetch_req=0.
REQ-030 SHALL cover: rst_n pulsed low at (500,300) -> outputs take reset values without waiting for a clock; restart at (0,0) with frame_start=1.
REQ-031 SHALL cover: with VIDEO_TEST_PATTERN_EN, x=0 -> rgb 000000, x=640 -> rgb FF00FF, x=1100 -> rgb 000000; without the macro -> rgb 000000 everywhere.
